// File: rtl/fas_fft_sched_pkg.sv
// Shared constants and types for the FAS FIR-to-FFT frame scheduler.
// Frame geometry, run length and launch FSM state encoding live here so the
// top, the frame bank and the interface all agree on widths.
package fas_fft_sched_pkg;

    localparam int FFT_N         = 16;
    localparam int SAMPLE_W      = 16;
    localparam int NUM_FRAMES    = 64;
    localparam int PTR_W         = 4;
    localparam int CNT_W         = 7;
    localparam int FRAME_W       = FFT_N * SAMPLE_W;
    localparam int TOTAL_SAMPLES = FFT_N * NUM_FRAMES;
    localparam int ACC_W         = 11;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [FRAME_W-1:0]  frame_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY,
        S_ANA,
        S_WAIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/fas_fft_sched_if.sv
// Bundle of FIR input, FFT core handshake, analysis handshake and status.
// master = scheduler side, slave = surrounding FAS datapath.
// Signal names follow the FAS top-level netlist.
interface fas_fft_sched_if;
    import fas_fft_sched_pkg::*;

    logic                 fir_valid;
    sample_t              fir_d;
    logic                 fft_ready;
    logic                 fft_start;
    frame_t               fft_frame;
    logic                 fft_res_valid;
    logic                 ana_start;
    logic                 ana_done;
    logic                 done;
    logic [CNT_W-1:0]     frame_cnt;
    logic                 overflow;

    modport master (
        input  fir_valid, fir_d, fft_ready, fft_res_valid, ana_done,
        output fft_start, fft_frame, ana_start, done, frame_cnt, overflow
    );

    modport slave (
        output fir_valid, fir_d, fft_ready, fft_res_valid, ana_done,
        input  fft_start, fft_frame, ana_start, done, frame_cnt, overflow
    );

endinterface

// File: rtl/fas_fft_sched_frame_bank.sv
// One 16-sample frame buffer: write port, full flag, release input.
// Latency: a write is visible on frame_o the cycle after; full rises with the 16th write.
// Backpressure: writes are ignored while full; only release_i empties the bank.
module fas_fft_sched_frame_bank
    import fas_fft_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [PTR_W-1:0] wr_addr_i,
    input  sample_t          wr_dat_i,
    input  logic             release_i,
    output logic             full_o,
    output frame_t           frame_o
);

    sample_t mem_q [FFT_N];
    logic    full_q;
    logic    wr_ok;

    assign wr_ok  = wr_en_i && !full_q;
    assign full_o = full_q;

    // Sample storage; reset clears it so a discarded partial frame never leaks out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < FFT_N; k++) begin
                mem_q[k] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    // Full flag: set by the last slot write, cleared when the FFT result comes back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
        end else if (wr_ok && (wr_addr_i == PTR_W'(FFT_N - 1))) begin
            full_q <= 1'b1;
        end else if (release_i) begin
            full_q <= 1'b0;
        end
    end

    // Flatten storage so slot k lands at bits [16*k +: 16], arrival order.
    always_comb begin
        frame_o = '0;
        for (int k = 0; k < FFT_N; k++) begin
            frame_o[k*SAMPLE_W +: SAMPLE_W] = mem_q[k];
        end
    end

endmodule

// File: rtl/fas_fft_sched.sv
// Ping-pong frame collection from the FIR and one FFT launch per full frame, then analysis.
// Latency: fft_start can fire the cycle after the edge that captured a frame's 16th sample.
// Backpressure: none toward the FIR; a sample aimed at a busy bank is dropped and flagged.
module fas_fft_sched
    import fas_fft_sched_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    fas_fft_sched_if.master    bus
);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic             fill_bank_q, fill_bank_d;
    logic [ACC_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             overflow_q, overflow_d;
    state_e           state_q, state_d;
    logic             launch_bank_q, launch_bank_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             done_q, done_d;

    logic [1:0]       bank_full;
    logic [1:0]       bank_wr;
    logic [1:0]       bank_rel;
    frame_t           bank_frame [2];

    logic             accept_open;
    logic             wr_ok;
    logic             drop;
    logic             fft_start;
    logic             ana_start;
    frame_t           frame_out;

    fas_fft_sched_frame_bank u_bank0 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (bank_wr[0]),
        .wr_addr_i (wptr_q),
        .wr_dat_i  (bus.fir_d),
        .release_i (bank_rel[0]),
        .full_o    (bank_full[0]),
        .frame_o   (bank_frame[0])
    );

    fas_fft_sched_frame_bank u_bank1 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (bank_wr[1]),
        .wr_addr_i (wptr_q),
        .wr_dat_i  (bus.fir_d),
        .release_i (bank_rel[1]),
        .full_o    (bank_full[1]),
        .frame_o   (bank_frame[1])
    );

    // Fill side: route accepted samples to the fill bank, drop into a full bank, stop after a run.
    always_comb begin
        accept_open = (acc_cnt_q != ACC_W'(TOTAL_SAMPLES));
        wr_ok       = bus.fir_valid && accept_open && !bank_full[fill_bank_q];
        drop        = bus.fir_valid && accept_open && bank_full[fill_bank_q];
        bank_wr     = 2'b00;
        wptr_d      = wptr_q;
        fill_bank_d = fill_bank_q;
        acc_cnt_d   = acc_cnt_q;
        overflow_d  = overflow_q || drop;
        if (wr_ok) begin
            bank_wr[fill_bank_q] = 1'b1;
            acc_cnt_d            = acc_cnt_q + ACC_W'(1);
            if (wptr_q == PTR_W'(FFT_N - 1)) begin
                wptr_d      = '0;
                fill_bank_d = ~fill_bank_q;
            end else begin
                wptr_d      = wptr_q + PTR_W'(1);
            end
        end
    end

    // Launch FSM next state and pulses; a full bank is only seen via its registered flag,
    // so a frame completed this cycle cannot launch before the next one.
    always_comb begin
        state_d       = state_q;
        launch_bank_d = launch_bank_q;
        frame_cnt_d   = frame_cnt_q;
        done_d        = done_q;
        fft_start     = 1'b0;
        ana_start     = 1'b0;
        bank_rel      = 2'b00;
        frame_out     = '0;
        case (state_q)
            S_IDLE: begin
                if (bank_full[launch_bank_q] && bus.fft_ready) begin
                    fft_start = 1'b1;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                frame_out = bank_frame[launch_bank_q];
                if (bus.fft_res_valid) begin
                    bank_rel[launch_bank_q] = 1'b1;
                    launch_bank_d           = ~launch_bank_q;
                    frame_cnt_d             = frame_cnt_q + CNT_W'(1);
                    state_d = (frame_cnt_q == CNT_W'(NUM_FRAMES - 1)) ? S_ANA : S_IDLE;
                end
            end
            S_ANA: begin
                ana_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ana_done) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Fill pointer, bank select, accepted-sample count and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            fill_bank_q <= 1'b0;
            acc_cnt_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            fill_bank_q <= fill_bank_d;
            acc_cnt_q   <= acc_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // FSM state, launch bank select, result counter and sticky done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            launch_bank_q <= 1'b0;
            frame_cnt_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            launch_bank_q <= launch_bank_d;
            frame_cnt_q   <= frame_cnt_d;
            done_q        <= done_d;
        end
    end

    assign bus.fft_start = fft_start;
    assign bus.fft_frame = frame_out;
    assign bus.ana_start = ana_start;
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.overflow  = overflow_q;

endmodule
